// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: decodes the instruction, resolves branches on alu_zero,
// and sequences the PC, IR, register-file and data-memory strobes.
module multicycle_ctrl #(
  parameter int COUNT_W      = 32,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  input  logic               dmem_ready,
  output logic [3:0]         alu_ctrl,
  output logic [4:0]         shamt,
  output logic               alu_src_b,
  output logic               reg_dst,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic               mem_to_reg,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_LW, C_SW, C_BR, C_J, C_HLT, C_ILL
  } cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d, dec_cls;
  logic [3:0]         alu_q, alu_d, dec_alu;
  logic [4:0]         shamt_q, shamt_d;
  logic               srcb_q, srcb_d;
  logic               rdst_q, rdst_d;
  logic               fault_q, fault_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] op, fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:11];

  always_comb begin
    dec_cls = C_ILL;
    dec_alu = 4'd0;
    unique case (op)
      6'h00: begin
        dec_cls = C_ALU;
        unique case (fn)
          6'h20:   dec_alu = 4'd0;
          6'h22:   dec_alu = 4'd1;
          6'h24:   dec_alu = 4'd2;
          6'h25:   dec_alu = 4'd3;
          6'h00:   dec_alu = 4'd4;
          6'h02:   dec_alu = 4'd5;
          6'h2A:   dec_alu = 4'd6;
          default: dec_cls = C_ILL;
        endcase
      end
      6'h08:   begin dec_cls = C_IMM; dec_alu = 4'd0;  end
      6'h0C:   begin dec_cls = C_IMM; dec_alu = 4'd2;  end
      6'h0D:   begin dec_cls = C_IMM; dec_alu = 4'd3;  end
      6'h23:   begin dec_cls = C_LW;  dec_alu = 4'd0;  end
      6'h2B:   begin dec_cls = C_SW;  dec_alu = 4'd0;  end
      6'h04:   begin dec_cls = C_BR;  dec_alu = 4'd7;  end
      6'h05:   begin dec_cls = C_BR;  dec_alu = 4'd8;  end
      6'h06:   begin dec_cls = C_BR;  dec_alu = 4'd9;  end
      6'h07:   begin dec_cls = C_BR;  dec_alu = 4'd10; end
      6'h09:   begin dec_cls = C_BR;  dec_alu = 4'd11; end
      6'h0A:   begin dec_cls = C_BR;  dec_alu = 4'd12; end
      6'h02:   dec_cls = C_J;
      6'h3F:   dec_cls = C_HLT;
      default: dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_d      = alu_q;
    shamt_d    = shamt_q;
    srcb_d     = srcb_q;
    rdst_d     = rdst_q;
    fault_d    = fault_q;
    wait_d     = '0;
    cnt_d      = cnt_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        alu_d   = dec_alu;
        shamt_d = instr[10:6];
        rdst_d  = (op == 6'h00);
        srcb_d  = (dec_cls == C_IMM) || (dec_cls == C_LW) ||
                  (dec_cls == C_SW);
        unique case (dec_cls)
          C_J: begin
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
          end
          C_HLT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_HALT;
          end
          C_ILL: begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (cls_q)
          C_BR: begin
            pc_src  = 2'b01;
            pc_we   = alu_zero;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        wait_d   = wait_q + 1'b1;
        // A ready on the final allowed cycle still completes the access.
        if (dmem_ready) begin
          wait_d = '0;
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WW'(MEM_WAIT_MAX - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls_q == C_LW);
        cnt_d      = cnt_q + 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      cls_q   <= C_ALU;
      alu_q   <= '0;
      shamt_q <= '0;
      srcb_q  <= 1'b0;
      rdst_q  <= 1'b0;
      fault_q <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      shamt_q <= shamt_d;
      srcb_q  <= srcb_d;
      rdst_q  <= rdst_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_ctrl    = alu_q;
  assign shamt       = shamt_q;
  assign alu_src_b   = srcb_q;
  assign reg_dst     = rdst_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; counter width 4 so wrap is reachable.
module tb_multicycle_ctrl;

  logic        clk, rst;
  logic [31:0] instr;
  logic        alu_zero, dmem_ready;
  logic [3:0]  alu_ctrl;
  logic [4:0]  shamt;
  logic        alu_src_b, reg_dst, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        reg_we, mem_to_reg, dmem_req, dmem_we;
  logic        halted, fault;
  logic [3:0]  instr_count;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.COUNT_W(4), .MEM_WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .alu_zero(alu_zero), .dmem_ready(dmem_ready),
    .alu_ctrl(alu_ctrl), .shamt(shamt),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .halted(halted), .fault(fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt(input logic [5:0] fn,
                                     input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0004};
  endfunction

  initial begin
    rst = 1'b1; instr = '0; alu_zero = 1'b0; dmem_ready = 1'b0;
    nx(); nx();
    chk("rst_alu", 32'(alu_ctrl), 0);
    chk("rst_irwe", 32'(ir_we), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(instr_count), 0);

    rst = 1'b0; instr = it(6'h02);
    nx();
    chk("fetch_irwe", 32'(ir_we), 1);
    chk("fetch_pcwe", 32'(pc_we), 1);
    chk("fetch_pcsrc", 32'(pc_src), 0);
    nx();
    chk("j_pcsrc", 32'(pc_src), 2);
    chk("j_pcwe", 32'(pc_we), 1);
    chk("j_irwe", 32'(ir_we), 0);
    nx();
    chk("j_cnt", 32'(instr_count), 1);

    // reset in the middle of an ADD
    instr = rt(6'h20, 5'd5);
    nx(); nx();
    chk("t1_shamt", 32'(shamt), 5);
    chk("t1_exec_regwe", 32'(reg_we), 0);
    rst = 1'b1; #1;
    chk("t1_rst_shamt", 32'(shamt), 0);
    chk("t1_rst_cnt", 32'(instr_count), 0);
    chk("t1_rst_irwe", 32'(ir_we), 0);
    chk("t1_rst_pcwe", 32'(pc_we), 0);
    nx(); rst = 1'b0;
    nx();
    chk("t1_fetch", 32'(ir_we), 1);

    // ADD then SLL sh=3
    instr = rt(6'h20, 5'd0);
    nx(); nx();
    chk("add_alu", 32'(alu_ctrl), 0);
    chk("add_srcb", 32'(alu_src_b), 0);
    chk("add_regwe_exec", 32'(reg_we), 0);
    nx();
    chk("add_regwe", 32'(reg_we), 1);
    chk("add_rdst", 32'(reg_dst), 1);
    chk("add_m2r", 32'(mem_to_reg), 0);
    nx();
    instr = rt(6'h00, 5'd3);
    nx();
    chk("sll_dec_hold", 32'(alu_ctrl), 0);
    nx();
    chk("sll_alu", 32'(alu_ctrl), 4);
    chk("sll_shamt", 32'(shamt), 3);
    nx();
    chk("sll_regwe", 32'(reg_we), 1);
    nx();
    chk("t2_cnt", 32'(instr_count), 2);

    // branches
    instr = it(6'h04);
    nx(); nx();
    alu_zero = 1'b1; #1;
    chk("beq_pcwe", 32'(pc_we), 1);
    chk("beq_pcsrc", 32'(pc_src), 1);
    chk("beq_alu", 32'(alu_ctrl), 7);
    nx();
    chk("beq_fetch", 32'(ir_we), 1);
    alu_zero = 1'b0; instr = it(6'h05);
    nx(); nx(); #1;
    chk("bne_pcwe", 32'(pc_we), 0);
    chk("bne_pcsrc", 32'(pc_src), 1);
    chk("bne_alu", 32'(alu_ctrl), 8);
    nx();
    chk("bne_fetch", 32'(ir_we), 1);
    chk("t3_cnt", 32'(instr_count), 4);

    // LW, ready in third MEM cycle
    instr = it(6'h23);
    nx(); nx();
    chk("lw_srcb", 32'(alu_src_b), 1);
    chk("lw_exec_req", 32'(dmem_req), 0);
    nx();
    chk("lw_m1_req", 32'(dmem_req), 1);
    chk("lw_m1_we", 32'(dmem_we), 0);
    nx();
    chk("lw_m2_req", 32'(dmem_req), 1);
    nx();
    dmem_ready = 1'b1; #1;
    chk("lw_m3_req", 32'(dmem_req), 1);
    nx();
    dmem_ready = 1'b0;
    chk("lw_wb_regwe", 32'(reg_we), 1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_req", 32'(dmem_req), 0);
    chk("lw_wb_rdst", 32'(reg_dst), 0);
    nx();
    chk("t4_cnt", 32'(instr_count), 5);

    // HALT
    instr = it(6'h3F);
    nx(); nx();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_fault", 32'(fault), 0);
    chk("hlt_cnt", 32'(instr_count), 6);
    chk("hlt_irwe", 32'(ir_we), 0);
    nx();
    chk("hlt_sticky", 32'(halted), 1);
    rst = 1'b1; #1;
    chk("hlt_rst", 32'(halted), 0);
    nx(); rst = 1'b0;
    nx();

    // illegal opcode after one J
    instr = it(6'h02);
    nx(); nx();
    instr = it(6'h11);
    nx(); nx();
    chk("ill_fault", 32'(fault), 1);
    chk("ill_halted", 32'(halted), 1);
    chk("ill_cnt", 32'(instr_count), 1);
    rst = 1'b1; nx(); rst = 1'b0;
    nx();

    // illegal R-type funct
    instr = rt(6'h21, 5'd0);
    nx(); nx();
    chk("illfn_fault", 32'(fault), 1);
    chk("illfn_cnt", 32'(instr_count), 0);
    rst = 1'b1; nx(); rst = 1'b0;
    nx();

    // counter wrap
    for (int i = 0; i < 15; i++) begin
      instr = it(6'h02);
      nx(); nx();
    end
    chk("wrap_15", 32'(instr_count), 15);
    nx(); nx();
    chk("wrap_0", 32'(instr_count), 0);

    // SW, ready on the last allowed MEM cycle
    instr = it(6'h2B);
    nx(); nx();
    repeat (15) nx();
    chk("sw_m15_req", 32'(dmem_req), 1);
    chk("sw_m15_we", 32'(dmem_we), 1);
    nx();
    dmem_ready = 1'b1;
    nx();
    dmem_ready = 1'b0;
    chk("sw16_fetch", 32'(ir_we), 1);
    chk("sw16_fault", 32'(fault), 0);
    chk("sw16_cnt", 32'(instr_count), 1);

    // SW timeout
    instr = it(6'h2B);
    nx(); nx();
    repeat (16) nx();
    chk("swto_m16_req", 32'(dmem_req), 1);
    chk("swto_m16_fault", 32'(fault), 0);
    chk("swto_m16_halt", 32'(halted), 0);
    nx();
    chk("swto_fault", 32'(fault), 1);
    chk("swto_halted", 32'(halted), 1);
    chk("swto_req", 32'(dmem_req), 0);
    nx();
    chk("swto_irwe", 32'(ir_we), 0);
    chk("swto_pcwe", 32'(pc_we), 0);
    chk("swto_cnt", 32'(instr_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
